// File: rtl/id_ex_if.sv
// ID/EX stage bundle: decode-side inputs, execute-side outputs and the
// forwarding/watchdog indications. The decode/hazard logic drives the master
// side and the pipeline register sits on the slave side.
//
// Flow control: there is no valid/ready pair. The stage always accepts, with a
// fixed priority at every rising edge of flush, then stall, then load.
//   flush - the stage is replaced by a bubble.
//   stall - the stage holds its contents.
//   load  - the stage takes the decode slot; validIn qualifies the slot.
// validOut qualifies every other EX-side field. wbOut is never 1 while
// validOut is 0.
interface id_ex_if #(
  parameter int DATA_W = 32
);
  logic              validIn;
  logic [2:0]        aluSigIn;
  logic              wbIn;
  logic [DATA_W-1:0] rsDataIn;
  logic [DATA_W-1:0] rtDataIn;
  logic [4:0]        rsAddrIn;
  logic [4:0]        rtAddrIn;
  logic [4:0]        rdAddrIn;
  logic              stall;
  logic              flush;
  logic              validOut;
  logic [2:0]        aluSigOut;
  logic              wbOut;
  logic [DATA_W-1:0] rsDataOut;
  logic [DATA_W-1:0] rtDataOut;
  logic [4:0]        rdAddrOut;
  logic              fwdA;
  logic              fwdB;
  logic              stallTimeout;

  modport master (
    output validIn, aluSigIn, wbIn, rsDataIn, rtDataIn,
    output rsAddrIn, rtAddrIn, rdAddrIn, stall, flush,
    input  validOut, aluSigOut, wbOut, rsDataOut, rtDataOut, rdAddrOut,
    input  fwdA, fwdB, stallTimeout
  );

  modport slave (
    input  validIn, aluSigIn, wbIn, rsDataIn, rtDataIn,
    input  rsAddrIn, rtAddrIn, rdAddrIn, stall, flush,
    output validOut, aluSigOut, wbOut, rsDataOut, rtDataOut, rdAddrOut,
    output fwdA, fwdB, stallTimeout
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register for the MIPS pipeline.
// Holds the ALU select, write-back flag, operands and destination for the
// instruction in EX. It also flags EX-stage forwarding hits for the
// instruction currently in decode, and raises a watchdog when the stage stays
// stalled for too long.
// Optional feature macro: ID_EX_PERF_EN adds the bubbleCnt output, a wrapping
// count of edges that leave a bubble in EX.
module id_ex_stage #(
  parameter int DATA_W    = 32,
  parameter int MAX_STALL = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  id_ex_if.slave      bus
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0] bubbleCnt
`endif
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_STALL);

  logic              valid_q,   valid_d;
  logic [2:0]        alu_q,     alu_d;
  logic              wb_q,      wb_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [4:0]        rd_q,      rd_d;
  logic [7:0]        stall_cnt_q, stall_cnt_d;
  logic              timeout_q, timeout_d;
  logic              do_flush, do_stall, do_load;

  // A flush wins even when stall is also high.
  assign do_flush = bus.flush;
  assign do_stall = bus.stall & ~bus.flush;
  assign do_load  = ~bus.stall & ~bus.flush;

  // Next-state selection: hold by default, then bubble on flush or load on load.
  always_comb begin
    valid_d   = valid_q;
    alu_d     = alu_q;
    wb_d      = wb_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    rd_d      = rd_q;
    if (do_flush) begin
      valid_d   = 1'b0;
      alu_d     = 3'd0;
      wb_d      = 1'b0;
      rs_data_d = '0;
      rt_data_d = '0;
      rd_d      = 5'd0;
    end else if (do_load) begin
      valid_d   = bus.validIn;
      alu_d     = bus.aluSigIn;
      wb_d      = bus.wbIn & bus.validIn;
      rs_data_d = bus.rsDataIn;
      rt_data_d = bus.rtDataIn;
      rd_d      = bus.rdAddrIn;
    end
  end

  // Stall watchdog: count consecutive stalls, saturate, and flag on reaching the limit.
  always_comb begin
    stall_cnt_d = 8'd0;
    if (do_stall) begin
      stall_cnt_d = (stall_cnt_q >= MAX_CNT) ? MAX_CNT : stall_cnt_q + 8'd1;
    end
    timeout_d = (stall_cnt_d == MAX_CNT);
  end

  // Pipeline register and watchdog state, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      alu_q       <= 3'd0;
      wb_q        <= 1'b0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      rd_q        <= 5'd0;
      stall_cnt_q <= 8'd0;
      timeout_q   <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      alu_q       <= alu_d;
      wb_q        <= wb_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      rd_q        <= rd_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

`ifdef ID_EX_PERF_EN
  logic [31:0] bubble_cnt_q;

  // Bubble counter: counts load or flush edges that leave EX empty, and wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_q <= 32'd0;
    end else if ((do_flush || do_load) && !valid_d) begin
      bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign bubbleCnt = bubble_cnt_q;
`endif

  assign bus.validOut     = valid_q;
  assign bus.aluSigOut    = alu_q;
  assign bus.wbOut        = wb_q;
  assign bus.rsDataOut    = rs_data_q;
  assign bus.rtDataOut    = rt_data_q;
  assign bus.rdAddrOut    = rd_q;
  assign bus.stallTimeout = timeout_q;

  // Register 0 is hard-wired to zero in MIPS, so it never forwards.
  assign bus.fwdA = valid_q & wb_q & (rd_q != 5'd0) & (bus.rsAddrIn == rd_q);
  assign bus.fwdB = valid_q & wb_q & (rd_q != 5'd0) & (bus.rtAddrIn == rd_q);

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage. Each directed or random step is predicted by a
// reference model of the stage contents and the length of the current stall
// run. Each prediction is queued in exp_q and checked one clock later.
// Inputs change on the falling edge, and outputs are sampled on the falling edge.
module tb_id_ex_stage;
  localparam int DATA_W    = 32;
  localparam int MAX_STALL = 4;
  localparam int W         = 1 + 3 + 1 + DATA_W + DATA_W + 5 + 1;

  logic clk;
  logic rst_n;
  id_ex_if #(.DATA_W(DATA_W)) bus ();
`ifdef ID_EX_PERF_EN
  logic [31:0] bubble_cnt;
`endif

  id_ex_stage #(.DATA_W(DATA_W), .MAX_STALL(MAX_STALL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ID_EX_PERF_EN
    ,
    .bubbleCnt (bubble_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model + scoreboard ----------------
  logic              m_valid, m_wb;
  logic [2:0]        m_alu;
  logic [DATA_W-1:0] m_rs, m_rt;
  logic [4:0]        m_rd;
  int                m_run;
  logic [31:0]       m_bub;
  logic [W-1:0]      exp_q[$];
  int                n_tests = 0;
  int                n_fail  = 0;

  function automatic logic [W-1:0] model_vec();
    return {m_valid, m_alu, m_wb, m_rs, m_rt, m_rd, (m_run >= MAX_STALL)};
  endfunction

  function automatic logic [W-1:0] obs_vec();
    return {bus.validOut, bus.aluSigOut, bus.wbOut, bus.rsDataOut, bus.rtDataOut,
            bus.rdAddrOut, bus.stallTimeout};
  endfunction

  function automatic logic [1:0] model_fwd();
    logic hit_ok;
    hit_ok = m_valid && m_wb && (m_rd != 5'd0);
    return {hit_ok && (bus.rsAddrIn == m_rd), hit_ok && (bus.rtAddrIn == m_rd)};
  endfunction

  function automatic void model_clear();
    m_valid = 1'b0; m_alu = 3'd0; m_wb = 1'b0;
    m_rs = '0; m_rt = '0; m_rd = 5'd0; m_run = 0; m_bub = 32'd0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [2:0] alu, input logic wb,
                       input logic [DATA_W-1:0] rsd, input logic [DATA_W-1:0] rtd,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic st, input logic fl);
    bus.validIn = v; bus.aluSigIn = alu; bus.wbIn = wb;
    bus.rsDataIn = rsd; bus.rtDataIn = rtd;
    bus.rsAddrIn = rs; bus.rtAddrIn = rt; bus.rdAddrIn = rd;
    bus.stall = st; bus.flush = fl;
  endtask

  // Predicts the effect of the coming rising edge, then advances to the next falling edge.
  task automatic clock_step();
    if (bus.flush) begin
      m_valid = 1'b0; m_alu = 3'd0; m_wb = 1'b0;
      m_rs = '0; m_rt = '0; m_rd = 5'd0;
      m_run = 0; m_bub = m_bub + 32'd1;
    end else if (bus.stall) begin
      m_run = m_run + 1;
    end else begin
      m_valid = bus.validIn; m_alu = bus.aluSigIn; m_wb = bus.wbIn & bus.validIn;
      m_rs = bus.rsDataIn; m_rt = bus.rtDataIn; m_rd = bus.rdAddrIn;
      m_run = 0;
      if (!bus.validIn) m_bub = m_bub + 32'd1;
    end
    exp_q.push_back(model_vec());
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    model_clear();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_tests++;
    if (obs_vec() !== '0) begin
      n_fail++; $display("FAIL reset_state: got %h expected 0", obs_vec());
    end
  endtask

  task automatic test_load();
    logic [W-1:0] e;
    drive(1, 3'd3, 1, 32'h10, 32'h22, 5'd1, 5'd2, 5'd5, 0, 0);
    clock_step();
    e = exp_q.pop_front();
    n_tests++;
    if (obs_vec() !== e) begin
      n_fail++; $display("FAIL load_model: got %h expected %h", obs_vec(), e);
    end
    n_tests++;
    if ({bus.validOut, bus.aluSigOut, bus.wbOut, bus.rdAddrOut, bus.rsDataOut} !==
        {1'b1, 3'd3, 1'b1, 5'd5, 32'h10}) begin
      n_fail++;
      $display("FAIL load_fields: got v=%0b alu=%0d wb=%0b rd=%0d rs=%h expected 1 3 1 5 10",
               bus.validOut, bus.aluSigOut, bus.wbOut, bus.rdAddrOut, bus.rsDataOut);
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] e;
    drive(1, 3'd2, 1, 32'hAAAA0001, 32'hBBBB0001, 5'd3, 5'd4, 5'd9, 0, 0);
    clock_step();
    e = exp_q.pop_front();
    n_tests++;
    if (obs_vec() !== e) begin
      n_fail++; $display("FAIL stall_pre: got %h expected %h", obs_vec(), e);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 3'(i), 0, $urandom, $urandom, 5'(i), 5'(i + 1), 5'(i + 10), 1, 0);
      clock_step();
      e = exp_q.pop_front();
      n_tests++;
      if (obs_vec() !== e) begin
        n_fail++; $display("FAIL stall_hold%0d: got %h expected %h", i, obs_vec(), e);
      end
    end
    drive(1, 3'd4, 0, 32'h12345678, 32'h9ABCDEF0, 5'd6, 5'd7, 5'd8, 0, 0);
    clock_step();
    e = exp_q.pop_front();
    n_tests++;
    if (obs_vec() !== e) begin
      n_fail++; $display("FAIL stall_release: got %h expected %h", obs_vec(), e);
    end
  endtask

  task automatic test_flush_stall();
    logic [W-1:0] e;
    drive(1, 3'd1, 1, 32'h55, 32'h66, 5'd1, 5'd2, 5'd3, 0, 0);
    clock_step();
    void'(exp_q.pop_front());
    drive(1, 3'd2, 1, 32'h77, 32'h88, 5'd1, 5'd2, 5'd4, 1, 0);
    clock_step(); clock_step();
    void'(exp_q.pop_front()); void'(exp_q.pop_front());
    drive(1, 3'd2, 1, 32'h77, 32'h88, 5'd1, 5'd2, 5'd4, 1, 1);
    clock_step();
    e = exp_q.pop_front();
    n_tests++;
    if (obs_vec() !== e || bus.validOut !== 1'b0 || bus.wbOut !== 1'b0) begin
      n_fail++; $display("FAIL flush_with_stall: got %h expected %h", obs_vec(), e);
    end
    // The counter restarted from zero, so MAX_STALL-1 stalls stay quiet and the next trips it.
    drive(1, 3'd2, 1, 32'h77, 32'h88, 5'd1, 5'd2, 5'd4, 1, 0);
    for (int i = 0; i < MAX_STALL; i++) begin
      clock_step();
      e = exp_q.pop_front();
      n_tests++;
      if (obs_vec() !== e) begin
        n_fail++; $display("FAIL flush_cnt_clear%0d: got %h expected %h", i, obs_vec(), e);
      end
    end
  endtask

  task automatic test_forward();
    logic [1:0] f;
    drive(1, 3'd0, 1, 32'h1, 32'h2, 5'd0, 5'd0, 5'd7, 0, 0);
    clock_step();
    void'(exp_q.pop_front());
    drive(1, 3'd0, 1, 32'h1, 32'h2, 5'd7, 5'd0, 5'd1, 0, 0);
    #1;
    f = model_fwd();
    n_tests++;
    if ({bus.fwdA, bus.fwdB} !== f || f !== 2'b10) begin
      n_fail++; $display("FAIL fwd_rd7: got %b%b expected %b (and 10)", bus.fwdA, bus.fwdB, f);
    end
    drive(1, 3'd0, 1, 32'h1, 32'h2, 5'd0, 5'd0, 5'd0, 0, 0);
    clock_step();
    void'(exp_q.pop_front());
    #1;
    f = model_fwd();
    n_tests++;
    if ({bus.fwdA, bus.fwdB} !== f || f !== 2'b00) begin
      n_fail++; $display("FAIL fwd_r0: got %b%b expected %b (and 00)", bus.fwdA, bus.fwdB, f);
    end
  endtask

  task automatic test_timeout();
    logic [W-1:0] e;
    drive(1, 3'd1, 1, 32'hCAFE, 32'hBEEF, 5'd1, 5'd2, 5'd3, 0, 0);
    clock_step();
    void'(exp_q.pop_front());
    drive(1, 3'd2, 0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1, 0);
    for (int i = 1; i <= 6; i++) begin
      clock_step();
      e = exp_q.pop_front();
      n_tests++;
      if (obs_vec() !== e || bus.stallTimeout !== (i >= 4)) begin
        n_fail++;
        $display("FAIL timeout_stall%0d: got %h to=%0b expected %h", i, obs_vec(),
                 bus.stallTimeout, e);
      end
    end
    drive(1, 3'd2, 0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 0);
    clock_step();
    e = exp_q.pop_front();
    n_tests++;
    if (obs_vec() !== e || bus.stallTimeout !== 1'b0) begin
      n_fail++; $display("FAIL timeout_drop: got %h expected %h", obs_vec(), e);
    end
  endtask

  task automatic test_async_reset();
    drive(1, 3'd4, 1, 32'hFFFF0000, 32'h0000FFFF, 5'd1, 5'd2, 5'd31, 0, 0);
    clock_step();
    void'(exp_q.pop_front());
    drive(1, 3'd1, 1, 32'h1, 32'h1, 5'd1, 5'd1, 5'd1, 1, 0);
    clock_step();
    void'(exp_q.pop_front());
    #2;
    rst_n = 1'b0;
    model_clear();
    exp_q.delete();
    #1;
    n_tests++;
    if (obs_vec() !== '0) begin
      n_fail++; $display("FAIL async_reset: got %h expected 0", obs_vec());
    end
`ifdef ID_EX_PERF_EN
    n_tests++;
    if (bubble_cnt !== 32'd0) begin
      n_fail++; $display("FAIL async_reset_bubble: got %0d expected 0", bubble_cnt);
    end
`endif
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    n_tests++;
    if (obs_vec() !== '0) begin
      n_fail++; $display("FAIL async_reset_held: got %h expected 0", obs_vec());
    end
  endtask

`ifdef ID_EX_PERF_EN
  task automatic test_bubble_cnt();
    do_reset();
    drive(1, 3'd1, 1, 32'h5, 32'h6, 5'd1, 5'd2, 5'd3, 0, 1);
    repeat (3) clock_step();
    exp_q.delete();
    n_tests++;
    if (bubble_cnt !== 32'd3 || bubble_cnt !== m_bub) begin
      n_fail++; $display("FAIL bubble_cnt3: got %0d expected 3", bubble_cnt);
    end
  endtask
`endif

  task automatic test_random();
    logic [W-1:0] e;
    logic [1:0]   f;
    int           st_pct;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      st_pct = ((i / 40) % 2 == 1) ? 80 : 30;
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 4)), 1'($urandom),
            $urandom, $urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), $urandom_range(0, 99) < st_pct,
            $urandom_range(0, 99) < 8);
      #1;
      f = model_fwd();
      n_tests++;
      if ({bus.fwdA, bus.fwdB} !== f) begin
        n_fail++; $display("FAIL rand_fwd%0d: got %b%b expected %b", i, bus.fwdA, bus.fwdB, f);
      end
      clock_step();
      e = exp_q.pop_front();
      n_tests++;
      if (obs_vec() !== e) begin
        n_fail++; $display("FAIL rand_out%0d: got %h expected %h", i, obs_vec(), e);
      end
`ifdef ID_EX_PERF_EN
      n_tests++;
      if (bubble_cnt !== m_bub) begin
        n_fail++; $display("FAIL rand_bubble%0d: got %0d expected %0d", i, bubble_cnt, m_bub);
      end
`endif
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    test_reset();
    test_load();
    test_stall();
    test_flush_stall();
    test_forward();
    test_timeout();
    test_async_reset();
`ifdef ID_EX_PERF_EN
    test_bubble_cnt();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Overall time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
